// File: rtl/sipo_vector_loader_if.sv
// Element stream into the vector loader.
// Master drives data/valid, slave returns ready.
interface sipo_vector_loader_if #(
  parameter int IWIDTH = 10
);
  logic [IWIDTH-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/sipo_vector_loader.sv
// Serial-in/parallel-out loader for the core's two operand vectors.
// One element per accepted beat, presented as registered vectors A and B.
module sipo_vector_loader #(
  parameter int IWIDTH  = 10,
  parameter int NINPUTS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              vec_sel,
  input  logic              abort,
  sipo_vector_loader_if.slave s,
  output logic [IWIDTH-1:0] data_A [NINPUTS],
  output logic [IWIDTH-1:0] data_B [NINPUTS],
  output logic              busy,
  output logic              load_done,
  output logic              loaded_A,
  output logic              loaded_B
);

  localparam int IW = (NINPUTS > 1) ? $clog2(NINPUTS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NINPUTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              sel_q, sel_d;
  logic              la_q, la_d;
  logic              lb_q, lb_d;
  logic              wr_a, wr_b;
  logic [IWIDTH-1:0] mem_a_q [NINPUTS];
  logic [IWIDTH-1:0] mem_b_q [NINPUTS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= 1'b0;
      la_q    <= 1'b0;
      lb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      la_q    <= la_d;
      lb_q    <= lb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    la_d    = la_q;
    lb_d    = lb_q;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          sel_d   = vec_sel;
          idx_d   = '0;
          state_d = LOAD;
          if (vec_sel) lb_d = 1'b0;
          else         la_d = 1'b0;
        end
      end
      LOAD: begin
        // abort wins over a beat presented in the same cycle
        if (abort) begin
          state_d = IDLE;
        end else if (s.in_valid) begin
          wr_a = !sel_q;
          wr_b = sel_q;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = DONE;
            if (sel_q) lb_d = 1'b1;
            else       la_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NINPUTS; i++) begin
        mem_a_q[i] <= '0;
      end
    end else if (wr_a) begin
      mem_a_q[idx_q] <= s.in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NINPUTS; i++) begin
        mem_b_q[i] <= '0;
      end
    end else if (wr_b) begin
      mem_b_q[idx_q] <= s.in_data;
    end
  end

  assign data_A     = mem_a_q;
  assign data_B     = mem_b_q;
  assign s.in_ready = (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign load_done  = (state_q == DONE);
  assign loaded_A   = la_q;
  assign loaded_B   = lb_q;

endmodule
